// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one valid/ready command into one
// AXI4-Lite write or read and returns the slave's response on a valid/ready port.
module axil_lite_master #(
  parameter int ADDR_W = 32
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WAIT_B = 3'd2,
    READ   = 3'd3,
    WAIT_R = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state_r;
  logic   aw_done_r;
  logic   w_done_r;
  logic   aw_fire_s;
  logic   w_fire_s;

  assign aw_fire_s    = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_fire_s     = M_AXI_WVALID & M_AXI_WREADY;
  assign cmd_ready    = (state_r == IDLE);
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // Transaction FSM; every AXI VALID/READY and response field is a register here.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_r       <= IDLE;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= 32'h0000_0000;
      M_AXI_WSTRB   <= 4'h0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= 32'h0000_0000;
      rsp_resp      <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_WDATA   <= cmd_wdata;
              M_AXI_WSTRB   <= cmd_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done_r     <= 1'b0;
              w_done_r      <= 1'b0;
              state_r       <= WRITE;
            end else begin
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARVALID <= 1'b1;
              state_r       <= READ;
            end
          end
        end
        WRITE: begin
          if (aw_fire_s) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done_r     <= 1'b1;
          end
          if (w_fire_s) begin
            M_AXI_WVALID <= 1'b0;
            w_done_r     <= 1'b1;
          end
          // The second handshake may land in this very cycle.
          if ((aw_done_r || aw_fire_s) && (w_done_r || w_fire_s)) begin
            M_AXI_BREADY <= 1'b1;
            state_r      <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_write    <= 1'b1;
            rsp_rdata    <= 32'h0000_0000;
            rsp_valid    <= 1'b1;
            state_r      <= RESP;
          end
        end
        READ: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state_r       <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_resp     <= M_AXI_RRESP;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            state_r      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID  <= 1'b0;
          M_AXI_ARVALID <= 1'b0;
          M_AXI_BREADY  <= 1'b0;
          M_AXI_RREADY  <= 1'b0;
          rsp_valid     <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_lite_master.sv
// Directed and randomised bench for axil_lite_master with a delay-programmable
// AXI4-Lite slave model, a protocol monitor and a reference memory.
module tb_axil_lite_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
  logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = 32'h0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0;
  logic aw_have = 1'b0, w_have = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic [31:0] sv_addr = 32'h0, sv_wdata = 32'h0, r_addr = 32'h0;
  logic [3:0]  sv_wstrb = 4'h0;
  bit [31:0] smem [64];
  bit [31:0] emem [64];

  logic aw_now, w_now, ar_now, wr_fire;
  logic [31:0] eff_addr, eff_data, merged;
  logic [3:0]  eff_strb;

  axil_lite_master #(.ADDR_W(32)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  assign aw_now   = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_now    = M_AXI_WVALID & M_AXI_WREADY;
  assign ar_now   = M_AXI_ARVALID & M_AXI_ARREADY;
  assign wr_fire  = (aw_have | aw_now) & (w_have | w_now);
  assign eff_addr = aw_now ? M_AXI_AWADDR : sv_addr;
  assign eff_data = w_now ? M_AXI_WDATA : sv_wdata;
  assign eff_strb = w_now ? M_AXI_WSTRB : sv_wstrb;
  assign merged   = merge(smem[eff_addr[7:2]], eff_data, eff_strb);

  always @(posedge clk) cyc <= cyc + 1;

  // Slave write side: AW/W ready delays, memory update, B response delay.
  always @(posedge clk) begin
    if (aw_now) begin
      aw_beats <= aw_beats + 1; aw_have <= 1'b1; sv_addr <= M_AXI_AWADDR;
      aw_hs_cyc <= cyc; M_AXI_AWREADY <= (aw_dly == 0); aw_cnt <= 0;
    end else if (M_AXI_AWVALID) begin
      if (aw_cnt + 1 >= aw_dly) M_AXI_AWREADY <= 1'b1;
      aw_cnt <= aw_cnt + 1;
    end else begin
      M_AXI_AWREADY <= (aw_dly == 0); aw_cnt <= 0;
    end
    if (w_now) begin
      w_beats <= w_beats + 1; w_have <= 1'b1; sv_wdata <= M_AXI_WDATA;
      sv_wstrb <= M_AXI_WSTRB; w_hs_cyc <= cyc; M_AXI_WREADY <= (w_dly == 0); w_cnt <= 0;
    end else if (M_AXI_WVALID) begin
      if (w_cnt + 1 >= w_dly) M_AXI_WREADY <= 1'b1;
      w_cnt <= w_cnt + 1;
    end else begin
      M_AXI_WREADY <= (w_dly == 0); w_cnt <= 0;
    end
    if (wr_fire) begin
      smem[eff_addr[7:2]] <= merged;
      aw_have <= 1'b0; w_have <= 1'b0;
      if (b_dly == 0) begin
        M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= bresp_val;
      end else begin
        b_pend <= 1'b1; b_cnt <= b_dly - 1;
      end
    end
    if (b_pend) begin
      if (b_cnt == 0) begin
        M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= bresp_val; b_pend <= 1'b0;
      end else b_cnt <= b_cnt - 1;
    end
    if (M_AXI_BVALID && M_AXI_BREADY) begin
      M_AXI_BVALID <= 1'b0; b_beats <= b_beats + 1;
    end
  end

  // Slave read side: AR ready delay and R response delay.
  always @(posedge clk) begin
    if (ar_now) begin
      ar_beats <= ar_beats + 1; M_AXI_ARREADY <= (ar_dly == 0); ar_cnt <= 0;
      if (r_dly == 0) begin
        M_AXI_RVALID <= 1'b1; M_AXI_RDATA <= smem[M_AXI_ARADDR[7:2]]; M_AXI_RRESP <= rresp_val;
      end else begin
        r_pend <= 1'b1; r_cnt <= r_dly - 1; r_addr <= M_AXI_ARADDR;
      end
    end else if (M_AXI_ARVALID) begin
      if (ar_cnt + 1 >= ar_dly) M_AXI_ARREADY <= 1'b1;
      ar_cnt <= ar_cnt + 1;
    end else begin
      M_AXI_ARREADY <= (ar_dly == 0); ar_cnt <= 0;
    end
    if (r_pend) begin
      if (r_cnt == 0) begin
        M_AXI_RVALID <= 1'b1; M_AXI_RDATA <= smem[r_addr[7:2]]; M_AXI_RRESP <= rresp_val;
        r_pend <= 1'b0;
      end else r_cnt <= r_cnt - 1;
    end
    if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
  end

  logic p_rst = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic p_arv = 1'b0, p_arr = 1'b0;
  logic [31:0] p_awaddr = 32'h0, p_wdata = 32'h0, p_araddr = 32'h0;
  logic [3:0]  p_wstrb = 4'h0;

  // Protocol monitor: VALID/payload held until handshake, dropped right after, BREADY after AW+W.
  always @(negedge clk) begin
    if (rst_n && p_rst) begin
      if (p_awv && !p_awr) chk("aw_hold", 64'({M_AXI_AWVALID, M_AXI_AWADDR}), 64'({1'b1, p_awaddr}));
      if (p_awv && p_awr)  chk("aw_drop", 64'(M_AXI_AWVALID), 64'd0);
      if (p_wv && !p_wr)   chk("w_hold", 64'({M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WDATA}),
                               64'({1'b1, p_wstrb, p_wdata}));
      if (p_wv && p_wr)    chk("w_drop", 64'(M_AXI_WVALID), 64'd0);
      if (p_arv && !p_arr) chk("ar_hold", 64'({M_AXI_ARVALID, M_AXI_ARADDR}), 64'({1'b1, p_araddr}));
      if (p_arv && p_arr)  chk("ar_drop", 64'(M_AXI_ARVALID), 64'd0);
      if (M_AXI_BREADY)    chk("bready_after_aw_w", {aw_beats, w_beats}, {b_beats + 1, b_beats + 1});
    end
    p_rst <= rst_n;
    p_awv <= M_AXI_AWVALID; p_awr <= M_AXI_AWREADY; p_awaddr <= M_AXI_AWADDR;
    p_wv <= M_AXI_WVALID; p_wr <= M_AXI_WREADY; p_wdata <= M_AXI_WDATA; p_wstrb <= M_AXI_WSTRB;
    p_arv <= M_AXI_ARVALID; p_arr <= M_AXI_ARREADY; p_araddr <= M_AXI_ARADDR;
  end

  task automatic do_cmd(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                        input int hold, output int lat, output int bready_cyc);
    int k;
    int ar0;
    ar0 = ar_beats;
    bready_cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_accept"}, 64'(cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 100) begin
      if (M_AXI_BREADY) bready_cyc++;
      if (!wr && ar_beats != ar0) chk({tag, "_rready"}, 64'(M_AXI_RREADY), 64'd1);
      @(negedge clk);
      k++;
    end
    lat = k;
    for (int h = 0; h <= hold; h++) begin
      chk({tag, "_rsp"}, 64'({rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata}),
          64'({1'b1, 1'b0, wr, exp_resp, exp_rdata}));
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_idle_again"}, 64'({cmd_ready, rsp_valid}), 64'd2);
    if (wr) emem[addr[7:2]] = merge(emem[addr[7:2]], wdata, strb);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, aw0, w0;
    logic wr;
    logic [31:0] a, d, er;
    logic [3:0] s;
    logic [1:0] ep;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({cmd_ready, rsp_valid, rsp_write, rsp_resp, M_AXI_AWVALID, M_AXI_WVALID,
                           M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}), 64'h200);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_addr", 64'({M_AXI_AWADDR, M_AXI_ARADDR}), 64'd0);
    chk("reset_wdata", 64'(M_AXI_WDATA), 64'd0);
    chk("reset_strb_prot", 64'({M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    aw0 = aw_beats; w0 = w_beats;
    do_cmd("wr_fast", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 0, lat, bc);
    chk("wr_fast_lat", 64'(lat), 64'd3);
    chk("wr_fast_bready_cycles", 64'(bc), 64'd1);
    chk("wr_fast_payload", {sv_addr, sv_wdata}, 64'h0000_0010_DEAD_BEEF);
    chk("wr_fast_strb", 64'(sv_wstrb), 64'hF);
    chk("wr_fast_same_cycle", 64'(aw_hs_cyc - w_hs_cyc), 64'd0);
    chk("wr_fast_beats", {aw_beats - aw0, w_beats - w0}, {32'd1, 32'd1});

    aw_dly = 3; aw0 = aw_beats; w0 = w_beats;
    do_cmd("wr_aw_late", 1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0, 2'b00, 0, lat, bc);
    chk("wr_aw_late_lat", 64'(lat), 64'd6);
    chk("wr_aw_late_gap", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
    chk("wr_aw_late_beats", {aw_beats - aw0, w_beats - w0}, {32'd1, 32'd1});
    chk("wr_aw_late_bready_cycles", 64'(bc), 64'd1);

    aw_dly = 0; w_dly = 3; aw0 = aw_beats; w0 = w_beats;
    do_cmd("wr_w_late", 1'b1, 32'h20, 32'hA5A5A5A5, 4'h5, 32'h0, 2'b00, 0, lat, bc);
    chk("wr_w_late_lat", 64'(lat), 64'd6);
    chk("wr_w_late_gap", 64'(w_hs_cyc - aw_hs_cyc), 64'd3);
    chk("wr_w_late_beats", {aw_beats - aw0, w_beats - w0}, {32'd1, 32'd1});

    w_dly = 0; r_dly = 4;
    do_cmd("rd_slow", 1'b0, 32'h400, 32'h0, 4'h0, 32'h12345678, 2'b00, 0, lat, bc);
    chk("rd_slow_lat", 64'(lat), 64'd7);
    chk("rd_slow_no_bready", 64'(bc), 64'd0);

    r_dly = 0; bresp_val = 2'b10;
    do_cmd("wr_bp_slverr", 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 32'h0, 2'b10, 10, lat, bc);
    chk("wr_bp_lat", 64'(lat), 64'd3);
    bresp_val = 2'b00;

    do_cmd("rd_strobed", 1'b0, 32'h20, 32'h0, 4'h0, 32'h00A500A5, 2'b00, 0, lat, bc);
    chk("rd_strobed_lat", 64'(lat), 64'd3);

    aw_dly = 10; w_dly = 10;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h11112222; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_pre_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY,
                          rsp_valid, cmd_ready}), 64'd1);
    aw_dly = 0; w_dly = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after", 64'({cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID}), 64'h8);
    do_cmd("rd_after_rst", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 0, lat, bc);
    chk("rd_after_rst_lat", 64'(lat), 64'd3);

    for (int i = 0; i < 1000; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_val = 2'($urandom_range(0, 3)); rresp_val = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_FF00) | {22'd0, 6'($urandom_range(0, 63)), 2'b00};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      er = wr ? 32'h0 : emem[a[7:2]];
      ep = wr ? bresp_val : rresp_val;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_cmd("rnd", wr, a, d, s, er, ep, $urandom_range(0, 2), lat, bc);
      chk("rnd_min_latency", 64'(lat >= 3), 64'd1);
      chk("rnd_bready_seen", 64'(bc > 0), 64'(wr));
      chk("rnd_beat_balance", {aw_beats, w_beats}, {b_beats, b_beats});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
